pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Program counter with branch/jump/JR selection, run/halt/fault FSM
//            and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] c_mem_words = 32'(MEM_SIZE);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_halted;
  logic        r_fault;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_next_pc;
  logic        w_next_valid;
  logic        w_unused_bits;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_br_off     = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign w_br_target  = w_pc_plus4 + w_br_off;
  assign w_jmp_target = {w_pc_plus4[31:28], instr[25:0], 2'b00};

  // Opcode bits are decoded upstream; only the immediate fields matter here.
  assign w_unused_bits = &{1'b0, instr[31:26]};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr)
      w_next_pc = rs_data;
    else if (jump)
      w_next_pc = w_jmp_target;
    else if (branch && zero)
      w_next_pc = w_br_target;
  end

  // Word-aligned and inside the instruction memory window.
  assign w_next_valid = (w_next_pc[1:0] == 2'b00) &&
                        ({2'b00, w_next_pc[31:2]} < c_mem_words);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!stall) begin
            if (!w_next_valid) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else if (w_next_pc == r_pc) begin
              r_state   <= ST_HALT;
              r_halted  <= 1'b1;
              r_retired <= r_retired + 32'd1;
            end else begin
              r_pc      <= w_next_pc;
              r_retired <= r_retired + 32'd1;
            end
          end
        end
        // HALT and FAULT are terminal until reset.
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign halted   = r_halted;
  assign fault    = r_fault;
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed self-checking bench for pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jr;
  logic [31:0] rs_data;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  pc_unit #(.RESET_PC(32'h0000_0000), .MEM_SIZE(128)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .jr       (jr),
    .rs_data  (rs_data),
    .stall    (stall),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    instr   = 32'd0;
    branch  = 1'b0;
    zero    = 1'b0;
    jump    = 1'b0;
    jr      = 1'b0;
    rs_data = 32'd0;
    stall   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset mid-low-phase, then advance n_edges plain RUN cycles.
  task automatic goto_pc(input int n_edges);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < n_edges; i++) step();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pc",      pc,             32'h0);
    check("rst_retired", retired,        32'd0);
    check("rst_halted",  {31'd0, halted}, 32'd0);
    check("rst_fault",   {31'd0, fault},  32'd0);
    check("rst_plus4",   pc_plus4,       32'h4);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    step(); check("seq_pc1", pc, 32'h4);
    step(); check("seq_pc2", pc, 32'h8);
    step(); check("seq_pc3", pc, 32'hC);
    check("seq_retired", retired, 32'd3);

    // Branch backwards: 0x14 + (-2<<2) = 0x0C
    goto_pc(4);
    check("br_start", pc, 32'h10);
    branch = 1'b1; zero = 1'b1; instr = 32'h0000_FFFE;
    step();
    check("br_back_pc", pc, 32'h0C);
    check("br_back_ret", retired, 32'd5);

    // Branch forward: 0x14 + 0xC = 0x20
    goto_pc(4);
    branch = 1'b1; zero = 1'b1; instr = 32'h0000_0003;
    step();
    check("br_fwd_pc", pc, 32'h20);

    // Branch not taken
    goto_pc(4);
    branch = 1'b1; zero = 1'b0; instr = 32'h0000_0003;
    step();
    check("br_nt_pc", pc, 32'h14);

    // JR beats jump
    goto_pc(2);
    check("jr_start", pc, 32'h8);
    jump = 1'b1; jr = 1'b1; rs_data = 32'h40; instr = 32'h0000_0005;
    step();
    check("jr_prio_pc", pc, 32'h40);

    // Plain jump
    goto_pc(2);
    jump = 1'b1; instr = 32'h0000_0005;
    step();
    check("jump_pc", pc, 32'h14);

    // Self-loop jump -> HALT
    goto_pc(3);
    check("halt_start", pc, 32'hC);
    jump = 1'b1; instr = 32'h0000_0003;
    step();
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_fault", {31'd0, fault}, 32'd0);
    check("halt_pc", pc, 32'hC);
    check("halt_ret", retired, 32'd4);
    @(negedge clk);
    jump = 1'b0; stall = 1'b1;
    step();
    @(negedge clk);
    stall = 1'b0; jr = 1'b1; rs_data = 32'h40;
    step();
    check("halt_sticky_pc", pc, 32'hC);
    check("halt_sticky_ret", retired, 32'd4);
    check("halt_sticky_flag", {31'd0, halted}, 32'd1);

    // Reset pulse while halted, between edges
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_flag", {31'd0, halted}, 32'd0);
    check("halt_rst_ret", retired, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_ret", retired, 32'd1);

    // Misaligned JR -> FAULT
    goto_pc(1);
    jr = 1'b1; rs_data = 32'h202;
    step();
    check("fault_mis_flag", {31'd0, fault}, 32'd1);
    check("fault_mis_halt", {31'd0, halted}, 32'd0);
    check("fault_mis_pc", pc, 32'h4);
    check("fault_mis_ret", retired, 32'd1);
    @(negedge clk);
    jr = 1'b0;
    step();
    check("fault_sticky_pc", pc, 32'h4);
    check("fault_sticky_flag", {31'd0, fault}, 32'd1);

    // First word beyond memory -> FAULT
    goto_pc(1);
    jr = 1'b1; rs_data = 32'h200;
    step();
    check("fault_oob_flag", {31'd0, fault}, 32'd1);
    check("fault_oob_pc", pc, 32'h4);

    // Last valid word is accepted
    goto_pc(1);
    jr = 1'b1; rs_data = 32'h1FC;
    step();
    check("edge_ok_pc", pc, 32'h1FC);
    check("edge_ok_fault", {31'd0, fault}, 32'd0);

    // Stall holds state for two edges
    goto_pc(1);
    stall = 1'b1; jump = 1'b1; instr = 32'h0000_0010;
    step();
    step();
    check("stall_pc", pc, 32'h4);
    check("stall_ret", retired, 32'd1);
    @(negedge clk);
    stall = 1'b0;
    step();
    check("unstall_pc", pc, 32'h40);
    check("unstall_ret", retired, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
